// File: rtl/mem_check_pkg.sv
// Shared definitions for the memory-write scoreboard: run states, failure
// codes and the width helpers used to size index and count fields.
package mem_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_RESERVED = 2'd3
  } fail_code_t;

  // Table index width; a single-entry table still needs one index bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold every value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Bundles the table-load port, run control, monitored memory write port and
// the status outputs of the write checker.
interface mem_write_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  import mem_check_pkg::*;

  localparam int IDXW = idx_width(DEPTH);
  localparam int CNTW = cnt_width(DEPTH);

  logic             exp_we;
  logic [IDXW-1:0]  exp_idx;
  logic [WIDTH-1:0] exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [CNTW-1:0]  num_exp;
  logic             start;

  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [CNTW-1:0]  match_count;
  logic [WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0] fail_data;

  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    output memwrite, dataadr, writedata,
    input  busy, done, pass, fail_code, match_count, fail_addr, fail_data
  );

  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    input  memwrite, dataadr, writedata,
    output busy, done, pass, fail_code, match_count, fail_addr, fail_data
  );

endinterface

// File: rtl/exp_table.sv
// Expected-write table: DEPTH (address, data) pairs with one write port, one
// indexed read port and a per-entry equality vector against a probe pair.
// The table has no reset so a loaded program survives a checker reset.
module exp_table
  import mem_check_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [idx_width(DEPTH)-1:0] widx_i,
  input  logic [WIDTH-1:0]            waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic [idx_width(DEPTH)-1:0] ridx_i,
  output logic [WIDTH-1:0]            raddr_o,
  output logic [WIDTH-1:0]            rdata_o,
  input  logic [WIDTH-1:0]            cmp_addr_i,
  input  logic [WIDTH-1:0]            cmp_data_i,
  output logic [DEPTH-1:0]            eq_o
);

  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  // Load one entry; indices past DEPTH (non power-of-two tables) are dropped.
  always_ff @(posedge clk) begin
    if (we_i && (int'(widx_i) < DEPTH)) begin
      addr_mem[widx_i] <= waddr_i;
      data_mem[widx_i] <= wdata_i;
    end
  end

  // Indexed read used by in-order checking; out-of-range reads return zero.
  always_comb begin
    raddr_o = '0;
    rdata_o = '0;
    if (int'(ridx_i) < DEPTH) begin
      raddr_o = addr_mem[ridx_i];
      rdata_o = data_mem[ridx_i];
    end
  end

  // Compare the probe against every entry at once for any-order checking.
  always_comb begin
    eq_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eq_o[i] = (addr_mem[i] == cmp_addr_i) && (data_mem[i] == cmp_data_i);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Scoreboard for the processor data-memory write port. Watches memwrite /
// dataadr / writedata during a run and compares them with a preloaded table
// of expected writes, reporting pass, mismatch or watchdog timeout.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096,
  parameter bit ORDERED = 1'b1,
  parameter bit STRICT  = 1'b0
) (
  input logic               clk,
  input logic               reset,
  mem_write_checker_if.slave bus
);

  localparam int IDXW = idx_width(DEPTH);
  localparam int CNTW = cnt_width(DEPTH);
  localparam int TMRW = $clog2(TIMEOUT + 1);

  localparam logic [CNTW-1:0] DEPTH_C      = CNTW'(DEPTH);
  localparam logic [TMRW-1:0] TIMEOUT_LAST = TMRW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNTW-1:0]  match_count_q, match_count_d;
  logic [CNTW-1:0]  num_q, num_d;
  logic [DEPTH-1:0] hit_q, hit_d;
  logic [TMRW-1:0]  tmr_q, tmr_d;
  fail_code_t       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;

  logic             table_we;
  logic [WIDTH-1:0] ord_addr;
  logic [WIDTH-1:0] ord_data;
  logic [DEPTH-1:0] eq_vec;
  logic [DEPTH-1:0] hit_sel;
  logic             any_match;
  logic             ord_match;
  logic             write_match;

  // The table may only change while no run is using it, and never in reset.
  assign table_we = bus.exp_we && !reset && (state_q != ST_RUN);

  exp_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk        (clk),
    .we_i       (table_we),
    .widx_i     (bus.exp_idx),
    .waddr_i    (bus.exp_addr),
    .wdata_i    (bus.exp_data),
    .ridx_i     (match_count_q[IDXW-1:0]),
    .raddr_o    (ord_addr),
    .rdata_o    (ord_data),
    .cmp_addr_i (bus.dataadr),
    .cmp_data_i (bus.writedata),
    .eq_o       (eq_vec)
  );

  // In-order match: the write must equal the next entry still outstanding.
  assign ord_match = (match_count_q < num_q) &&
                     (ord_addr == bus.dataadr) && (ord_data == bus.writedata);

  // Any-order match: pick the lowest-index valid entry not yet hit.
  always_comb begin
    hit_sel   = '0;
    any_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!any_match && eq_vec[i] && !hit_q[i] && (i < int'(num_q))) begin
        any_match  = 1'b1;
        hit_sel[i] = 1'b1;
      end
    end
  end

  assign write_match = ORDERED ? ord_match : any_match;

  // Next-state logic: run start, write evaluation, completion and watchdog.
  always_comb begin
    state_d       = state_q;
    match_count_d = match_count_q;
    num_d         = num_q;
    hit_d         = hit_q;
    tmr_d         = tmr_q;
    fail_code_d   = fail_code_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          match_count_d = '0;
          hit_d         = '0;
          tmr_d         = '0;
          fail_code_d   = FC_NONE;
          fail_addr_d   = '0;
          fail_data_d   = '0;
          num_d         = (bus.num_exp > DEPTH_C) ? DEPTH_C : bus.num_exp;
        end
      end

      ST_RUN: begin
        tmr_d = tmr_q + 1'b1;
        if (match_count_q == num_q) begin
          // Only reachable with an empty table: nothing to wait for.
          state_d = ST_PASS;
        end else begin
          if (bus.memwrite && write_match) begin
            match_count_d = match_count_q + 1'b1;
            hit_d         = hit_q | hit_sel;
          end
          // The write is judged before the watchdog so a completing write
          // on the last allowed cycle still passes.
          if (bus.memwrite && !write_match && STRICT) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_MISMATCH;
            fail_addr_d = bus.dataadr;
            fail_data_d = bus.writedata;
          end else if (match_count_d == num_q) begin
            state_d = ST_PASS;
          end else if (tmr_q == TIMEOUT_LAST) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_TIMEOUT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; the table itself is untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      match_count_q <= '0;
      num_q         <= '0;
      hit_q         <= '0;
      tmr_q         <= '0;
      fail_code_q   <= FC_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      match_count_q <= match_count_d;
      num_q         <= num_d;
      hit_q         <= hit_d;
      tmr_q         <= tmr_d;
      fail_code_q   <= fail_code_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign bus.pass        = (state_q == ST_PASS);
  assign bus.fail_code   = fail_code_q;
  assign bus.match_count = match_count_q;
  assign bus.fail_addr   = fail_addr_q;
  assign bus.fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: four instances covering every ordered/strict
// combination share one stimulus stream and are compared each cycle with a
// queue-based reference model, plus directed scenario checks.
module tb_mem_write_checker;

  localparam int W    = 32;
  localparam int D    = 4;
  localparam int TMO  = 16;
  localparam int NCFG = 4;

  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;

  logic        clk;
  logic        reset;
  logic        expWe;
  logic [1:0]  expIdx;
  logic [31:0] expAddr;
  logic [31:0] expData;
  logic [2:0]  numExp;
  logic        start;
  logic        memWrite;
  logic [31:0] dataAdr;
  logic [31:0] writeData;

  logic        obsBusy  [NCFG];
  logic        obsDone  [NCFG];
  logic        obsPass  [NCFG];
  logic [1:0]  obsFc    [NCFG];
  logic [2:0]  obsMatch [NCFG];
  logic [31:0] obsFa    [NCFG];
  logic [31:0] obsFd    [NCFG];

  int testsRun;
  int testsFailed;

  // Reference model state, one copy per configuration.
  mstate_t     mState   [NCFG];
  logic [31:0] mTabA    [NCFG][D];
  logic [31:0] mTabD    [NCFG][D];
  int          mNum     [NCFG];
  int          mMatched [NCFG];
  int          mCycles  [NCFG];
  int          mFc      [NCFG];
  logic [31:0] mFa      [NCFG];
  logic [31:0] mFd      [NCFG];
  int          mPending [NCFG][$];

  // Configuration c: c<2 ordered, odd c strict.
  for (genvar g = 0; g < NCFG; g++) begin : gCfg
    mem_write_checker_if #(.WIDTH(W), .DEPTH(D)) ifc ();

    assign ifc.exp_we    = expWe;
    assign ifc.exp_idx   = expIdx;
    assign ifc.exp_addr  = expAddr;
    assign ifc.exp_data  = expData;
    assign ifc.num_exp   = numExp;
    assign ifc.start     = start;
    assign ifc.memwrite  = memWrite;
    assign ifc.dataadr   = dataAdr;
    assign ifc.writedata = writeData;

    assign obsBusy[g]  = ifc.busy;
    assign obsDone[g]  = ifc.done;
    assign obsPass[g]  = ifc.pass;
    assign obsFc[g]    = ifc.fail_code;
    assign obsMatch[g] = ifc.match_count;
    assign obsFa[g]    = ifc.fail_addr;
    assign obsFd[g]    = ifc.fail_data;

    mem_write_checker #(
      .WIDTH   (W),
      .DEPTH   (D),
      .TIMEOUT (TMO),
      .ORDERED (g < 2),
      .STRICT  (g % 2 == 1)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
    );
  end

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, got, want);
    end
  endtask

  // Advance the model by one clock using the inputs presented at the edge.
  task automatic modelStep(input int c);
    bit ordered;
    bit strict;
    bit ok;
    ordered = (c < 2);
    strict  = (c % 2 == 1);
    ok      = 1'b0;
    if (reset) begin
      mState[c] = M_IDLE; mNum[c] = 0; mMatched[c] = 0; mCycles[c] = 0;
      mFc[c] = 0; mFa[c] = '0; mFd[c] = '0;
      mPending[c].delete();
      return;
    end
    if (mState[c] != M_RUN) begin
      if (expWe) begin
        mTabA[c][expIdx] = expAddr;
        mTabD[c][expIdx] = expData;
      end
      if (start) begin
        mState[c]   = M_RUN;
        mNum[c]     = (int'(numExp) > D) ? D : int'(numExp);
        mMatched[c] = 0; mCycles[c] = 0; mFc[c] = 0; mFa[c] = '0; mFd[c] = '0;
        mPending[c].delete();
        for (int i = 0; i < mNum[c]; i++) mPending[c].push_back(i);
      end
      return;
    end
    mCycles[c]++;
    if (mMatched[c] == mNum[c]) begin
      mState[c] = M_PASS;
      return;
    end
    if (memWrite) begin
      if (ordered) begin
        ok = (mTabA[c][mMatched[c]] == dataAdr) && (mTabD[c][mMatched[c]] == writeData);
      end else begin
        for (int j = 0; j < mPending[c].size(); j++) begin
          if (!ok && mTabA[c][mPending[c][j]] == dataAdr && mTabD[c][mPending[c][j]] == writeData) begin
            ok = 1'b1;
            mPending[c].delete(j);
          end
        end
      end
      if (ok) begin
        mMatched[c]++;
      end else if (strict) begin
        mState[c] = M_FAIL; mFc[c] = 1; mFa[c] = dataAdr; mFd[c] = writeData;
        return;
      end
    end
    if (mMatched[c] == mNum[c]) mState[c] = M_PASS;
    else if (mCycles[c] >= TMO) mState[c] = M_FAIL;
  endtask

  task automatic checkAll();
    for (int c = 0; c < NCFG; c++) begin
      checkOutput($sformatf("cfg%0d.busy", c),  32'(obsBusy[c]),  32'(mState[c] == M_RUN));
      checkOutput($sformatf("cfg%0d.done", c),  32'(obsDone[c]),  32'(mState[c] == M_PASS || mState[c] == M_FAIL));
      checkOutput($sformatf("cfg%0d.pass", c),  32'(obsPass[c]),  32'(mState[c] == M_PASS));
      checkOutput($sformatf("cfg%0d.fcode", c), 32'(obsFc[c]),    32'(mState[c] == M_FAIL ? (mFc[c] == 1 ? 1 : 2) : mFc[c]));
      checkOutput($sformatf("cfg%0d.match", c), 32'(obsMatch[c]), 32'(mMatched[c]));
      checkOutput($sformatf("cfg%0d.faddr", c), obsFa[c],         mFa[c]);
      checkOutput($sformatf("cfg%0d.fdata", c), obsFd[c],         mFd[c]);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    for (int c = 0; c < NCFG; c++) modelStep(c);
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic st, input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    expWe     = 1'b0;
    start     = st;
    memWrite  = mw;
    dataAdr   = adr;
    writeData = wd;
    stepCycle();
  endtask

  task automatic loadEntry(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    expWe    = 1'b1;
    expIdx   = idx;
    expAddr  = a;
    expData  = d;
    start    = 1'b0;
    memWrite = 1'b0;
    stepCycle();
    expWe    = 1'b0;
  endtask

  function automatic logic [31:0] poolAddr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'(80 + 4 * $urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] poolData();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(5, 7));
  endfunction

  initial begin
    int rc;
    int ri;
    testsRun = 0; testsFailed = 0;
    reset = 1'b1; expWe = 1'b0; expIdx = '0; expAddr = '0; expData = '0;
    numExp = '0; start = 1'b0; memWrite = 1'b0; dataAdr = '0; writeData = '0;
    for (int c = 0; c < NCFG; c++) begin
      mState[c] = M_IDLE; mNum[c] = 0; mMatched[c] = 0; mCycles[c] = 0;
      mFc[c] = 0; mFa[c] = '0; mFd[c] = '0;
      for (int i = 0; i < D; i++) begin mTabA[c][i] = '0; mTabD[c][i] = '0; end
    end

    // Reset: every status output reads zero.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int c = 0; c < NCFG; c++) begin
      checkOutput($sformatf("rst.done%0d", c), 32'(obsDone[c]), 0);
      checkOutput($sformatf("rst.busy%0d", c), 32'(obsBusy[c]), 0);
    end
    reset = 1'b0;

    // Fill every table slot so later runs never read unloaded entries.
    loadEntry(0, 84, 7);
    loadEntry(1, 200, 1);
    loadEntry(2, 204, 2);
    loadEntry(3, 208, 3);

    // Single write at address 84 with data 7.
    numExp = 3'd1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("single.busy", 32'(obsBusy[0]), 1);
    checkOutput("single.doneEarly", 32'(obsDone[0]), 0);
    applyStimulus(0, 1, 84, 7);
    checkOutput("single.done", 32'(obsDone[0]), 1);
    checkOutput("single.pass", 32'(obsPass[0]), 1);
    checkOutput("single.match", 32'(obsMatch[0]), 1);
    checkOutput("single.fcode", 32'(obsFc[0]), 0);
    applyStimulus(0, 0, 0, 0);

    // Two entries written in reverse order.
    loadEntry(0, 80, 5);
    loadEntry(1, 84, 7);
    numExp = 3'd2;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 84, 7);
    checkOutput("rev.ordStrictFcode", 32'(obsFc[1]), 1);
    checkOutput("rev.ordStrictFaddr", obsFa[1], 84);
    checkOutput("rev.ordStrictFdata", obsFd[1], 7);
    applyStimulus(0, 1, 80, 5);
    checkOutput("rev.anyStrictPass", 32'(obsPass[3]), 1);
    checkOutput("rev.anyLoosePass", 32'(obsPass[2]), 1);
    checkOutput("rev.ordLooseMatch", 32'(obsMatch[0]), 1);

    // Repeated write to an already-hit entry under any-order strict mode.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 84, 7);
    applyStimulus(0, 1, 84, 7);
    checkOutput("repeat.fcode", 32'(obsFc[3]), 1);
    checkOutput("repeat.faddr", obsFa[3], 84);
    checkOutput("repeat.done", 32'(obsDone[3]), 1);

    // Let every instance settle, then a watchdog run with a stray start.
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0);
    numExp = 3'd1;
    applyStimulus(1, 0, 0, 0);
    for (int k = 1; k <= TMO; k++) begin
      applyStimulus(k == 5, 0, 0, 0);
      if (k == TMO - 1) checkOutput("tmo.busyLast", 32'(obsBusy[0]), 1);
    end
    for (int c = 0; c < NCFG; c++) begin
      checkOutput($sformatf("tmo.done%0d", c), 32'(obsDone[c]), 1);
      checkOutput($sformatf("tmo.fcode%0d", c), 32'(obsFc[c]), 2);
      checkOutput($sformatf("tmo.faddr%0d", c), obsFa[c], 0);
    end

    // Empty expectation list passes on the first run cycle.
    numExp = 3'd0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("empty.busy", 32'(obsBusy[2]), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("empty.pass", 32'(obsPass[2]), 1);
    checkOutput("empty.match", 32'(obsMatch[2]), 0);

    // Reset in the middle of a run, then a fresh run on the retained table.
    numExp = 3'd2;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 80, 5);
    checkOutput("abort.matchBefore", 32'(obsMatch[0]), 1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      checkOutput($sformatf("abort.busy%0d", c), 32'(obsBusy[c]), 0);
      checkOutput($sformatf("abort.match%0d", c), 32'(obsMatch[c]), 0);
      checkOutput($sformatf("abort.done%0d", c), 32'(obsDone[c]), 0);
    end
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 80, 5);
    applyStimulus(0, 1, 84, 7);
    for (int c = 0; c < NCFG; c++) begin
      checkOutput($sformatf("rerun.pass%0d", c), 32'(obsPass[c]), 1);
      checkOutput($sformatf("rerun.match%0d", c), 32'(obsMatch[c]), 2);
    end

    // Randomised traffic with table-biased writes.
    for (int cyc = 0; cyc < 1200; cyc++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 99) < 6);
      numExp   = 3'($urandom_range(0, 7));
      expWe    = !reset && ($urandom_range(0, 99) < 8);
      expIdx   = 2'($urandom_range(0, 3));
      expAddr  = poolAddr();
      expData  = poolData();
      memWrite = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 60) begin
        rc = $urandom_range(0, NCFG - 1);
        ri = $urandom_range(0, D - 1);
        dataAdr   = mTabA[rc][ri];
        writeData = mTabD[rc][ri];
      end else begin
        dataAdr   = poolAddr();
        writeData = poolData();
      end
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
